// File: rtl/sdfa_snn_top.sv
`default_nettype none
// ============================================================================
// Module   : sdfa_snn_top
// Brief    : Single-layer spiking classifier. Serially configured, binarises
//            pixels against a threshold, integrates signed weights into class
//            membranes and emits the winning class as a serial one-hot train.
//            Optional macro SDFA_OUT_THRESH_EN gates the winner spike on out_thr.
// Revision : 1.0 - initial release
// ============================================================================
module sdfa_snn_top #(
    parameter int DATA_W    = 64,
    parameter int PIX_W     = 8,
    parameter int NUM_WORDS = 98,
    parameter int NUM_CLASS = 10,
    parameter int WEIGHT_W  = 14,
    parameter int ACC_W     = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pixel_valid,
    input  logic              train,
    input  logic              set_number,
    input  logic              set_valid,
    input  logic              master_inf_valid,
    input  logic              block_inf_valid,
    input  logic              master_in,
    input  logic              block_in,
    output logic              image_req,
    output logic              set_up_req,
    output logic              result_spike,
    output logic              result_spike_valid
);
    localparam int c_PPW     = DATA_W / PIX_W;
    localparam int c_NUM_PIX = NUM_WORDS * c_PPW;
    localparam int c_WORD_W  = $clog2(NUM_WORDS);
    localparam int c_SUB_W   = $clog2(c_PPW);
    localparam int c_PIDX_W  = c_WORD_W + c_SUB_W;
    localparam int c_CLS_W   = $clog2(NUM_CLASS);
    localparam int c_INIT_W  = 16;
    // Reserved chain bits never influence behaviour, so only the live low bits are kept.
`ifdef SDFA_OUT_THRESH_EN
    localparam int c_MST_KEEP = NUM_CLASS + ACC_W;
`else
    localparam int c_MST_KEEP = NUM_CLASS;
`endif

    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(NUM_WORDS - 1);
    localparam logic [c_CLS_W-1:0]  c_OUT_END   = c_CLS_W'(NUM_CLASS);
    localparam logic [c_CLS_W-1:0]  c_NCLS      = c_CLS_W'(NUM_CLASS);
    localparam logic [c_PIDX_W-1:0] c_NPIX      = c_PIDX_W'(c_NUM_PIX);

    localparam logic [2:0] c_ST_CFG    = 3'd0;
    localparam logic [2:0] c_ST_IDLE   = 3'd1;
    localparam logic [2:0] c_ST_LOAD   = 3'd2;
    localparam logic [2:0] c_ST_DECIDE = 3'd3;
    localparam logic [2:0] c_ST_OUT    = 3'd4;

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [PIX_W-1:0]          r_set_chain;
    logic [c_MST_KEEP-1:0]     r_mst_chain;
    logic [c_INIT_W-1:0]       r_blk_chain;
    logic [2:0]                r_seen;
    logic [c_WORD_W-1:0]       r_cnt;
    logic [c_CLS_W-1:0]        r_idx;
    logic [c_CLS_W-1:0]        r_winner;
    logic                      r_fire;
    logic                      r_spike;
    logic                      r_spike_valid;
    logic                      r_image_req;
    logic                      r_set_up_req;
    logic signed [ACC_W-1:0]   r_v [NUM_CLASS];
    logic signed [WEIGHT_W-1:0] r_weight [c_NUM_PIX][NUM_CLASS];

    logic [c_WORD_W-1:0]       w_word;
    logic [c_PPW-1:0]          w_spike;
    logic [c_PIDX_W-1:0]       w_pix_idx [c_PPW];
    logic signed [ACC_W-1:0]   w_sum [NUM_CLASS];
    logic signed [ACC_W-1:0]   w_init_ext;
    logic signed [ACC_W-1:0]   w_best;
    logic [c_CLS_W-1:0]        w_win;
    logic                      w_has;
    logic                      w_fire;
    logic [c_CLS_W-1:0]        w_wr_cls;
    logic [c_PIDX_W-1:0]       w_wr_pix;
    logic                      w_wr_en;

    assign w_init_ext = ACC_W'($signed(r_blk_chain));
    assign w_word     = (r_state == c_ST_IDLE) ? '0 : r_cnt;

    for (genvar i = 0; i < c_PPW; i++) begin : g_pix
        assign w_spike[i]   = data_in[i*PIX_W +: PIX_W] >= r_set_chain;
        assign w_pix_idx[i] = {w_word, c_SUB_W'(i)};
    end

    always_comb begin
        for (int c = 0; c < NUM_CLASS; c++) begin
            w_sum[c] = '0;
            for (int i = 0; i < c_PPW; i++) begin
                if (w_spike[i]) w_sum[c] = w_sum[c] + ACC_W'(r_weight[w_pix_idx[i]][c]);
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_has  = 1'b0;
        w_win  = '0;
        w_best = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            if (r_mst_chain[c] && (!w_has || r_v[c] > w_best)) begin
                w_has  = 1'b1;
                w_win  = c_CLS_W'(c);
                w_best = r_v[c];
            end
        end
`ifdef SDFA_OUT_THRESH_EN
        w_fire = w_has && (w_best >= $signed(r_mst_chain[NUM_CLASS +: ACC_W]));
`else
        w_fire = w_has;
`endif
    end

    assign w_wr_cls = data_in[WEIGHT_W +: c_CLS_W];
    assign w_wr_pix = data_in[WEIGHT_W + c_CLS_W +: c_PIDX_W];
    assign w_wr_en  = !rstn && (r_state == c_ST_IDLE) && pixel_valid && train &&
                      (w_wr_cls < c_NCLS) && (w_wr_pix < c_NPIX);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_weight[w_wr_pix][w_wr_cls] <= data_in[WEIGHT_W-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CFG:    if (&r_seen && !(set_valid || master_inf_valid || block_inf_valid))
                             w_state_nxt = c_ST_IDLE;
            c_ST_IDLE:   if (pixel_valid && !train) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:   if (pixel_valid && r_cnt == c_LAST_WORD) w_state_nxt = c_ST_DECIDE;
            c_ST_DECIDE: w_state_nxt = c_ST_OUT;
            c_ST_OUT:    if (r_idx == c_OUT_END) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_CFG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state       <= c_ST_CFG;
            r_set_chain   <= '0;
            r_mst_chain   <= '0;
            r_blk_chain   <= '0;
            r_seen        <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_winner      <= '0;
            r_fire        <= 1'b0;
            r_spike       <= 1'b0;
            r_spike_valid <= 1'b0;
            r_image_req   <= 1'b0;
            r_set_up_req  <= 1'b1;
            for (int c = 0; c < NUM_CLASS; c++) r_v[c] <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_image_req  <= (w_state_nxt == c_ST_IDLE);
            r_set_up_req <= (w_state_nxt == c_ST_CFG);
            case (r_state)
                c_ST_CFG: begin
                    if (set_valid)        r_set_chain <= {r_set_chain[PIX_W-2:0], set_number};
                    if (master_inf_valid) r_mst_chain <= {r_mst_chain[c_MST_KEEP-2:0], master_in};
                    if (block_inf_valid)  r_blk_chain <= {r_blk_chain[c_INIT_W-2:0], block_in};
                    r_seen <= r_seen | {block_inf_valid, master_inf_valid, set_valid};
                end
                c_ST_IDLE: begin
                    if (pixel_valid && !train) begin
                        for (int c = 0; c < NUM_CLASS; c++) r_v[c] <= w_init_ext + w_sum[c];
                        r_cnt <= c_WORD_W'(1);
                    end
                end
                c_ST_LOAD: begin
                    if (pixel_valid) begin
                        for (int c = 0; c < NUM_CLASS; c++) r_v[c] <= r_v[c] + w_sum[c];
                        r_cnt <= (r_cnt == c_LAST_WORD) ? '0 : r_cnt + c_WORD_W'(1);
                    end
                end
                c_ST_DECIDE: begin
                    r_winner      <= w_win;
                    r_fire        <= w_fire;
                    r_spike       <= w_fire && (w_win == '0);
                    r_spike_valid <= 1'b1;
                    r_idx         <= c_CLS_W'(1);
                end
                c_ST_OUT: begin
                    if (r_idx == c_OUT_END) begin
                        r_spike       <= 1'b0;
                        r_spike_valid <= 1'b0;
                        r_idx         <= '0;
                    end else begin
                        r_spike <= r_fire && (r_idx == r_winner);
                        r_idx   <= r_idx + c_CLS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign image_req          = r_image_req;
    assign set_up_req         = r_set_up_req;
    assign result_spike       = r_spike;
    assign result_spike_valid = r_spike_valid;

endmodule
`default_nettype wire

// File: tb/tb_sdfa_snn_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdfa_snn_top
// Brief    : Self-checking bench for sdfa_snn_top against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdfa_snn_top;
    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] data_in;
    logic        pixel_valid, train, set_number, set_valid;
    logic        master_inf_valid, block_inf_valid, master_in, block_in;
    logic        image_req, set_up_req, result_spike, result_spike_valid;

    sdfa_snn_top dut (
        .clk(clk), .rstn(rstn), .data_in(data_in), .pixel_valid(pixel_valid),
        .train(train), .set_number(set_number), .set_valid(set_valid),
        .master_inf_valid(master_inf_valid), .block_inf_valid(block_inf_valid),
        .master_in(master_in), .block_in(block_in), .image_req(image_req),
        .set_up_req(set_up_req), .result_spike(result_spike),
        .result_spike_valid(result_spike_valid)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          exp_v [int];
    bit          exp_s [int];
    logic [9:0]  obs_bits;
    int          obs_n;

    int          mw [784][10];
    logic [7:0]  img [784];
    int          m_thr, m_init, m_othr;
    logic [9:0]  m_en;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Result outputs are checked every cycle against the scheduled expectation.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            chk("result_spike_valid", result_spike_valid, exp_v.exists(cyc) ? exp_v[cyc] : 1'b0);
            chk("result_spike", result_spike, exp_s.exists(cyc) ? exp_s[cyc] : 1'b0);
            if (result_spike_valid === 1'b1 && obs_n < 10) begin
                obs_bits[obs_n] = result_spike;
                obs_n++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_result(output logic [9:0] oh);
        longint v [10];
        int     win;
        bit     fire;
        for (int c = 0; c < 10; c++) v[c] = m_init;
        for (int p = 0; p < 784; p++)
            if (int'(img[p]) >= m_thr)
                for (int c = 0; c < 10; c++) v[c] += mw[p][c];
        win = -1;
        for (int c = 0; c < 10; c++)
            if (m_en[c] && (win < 0 || v[c] > v[win])) win = c;
        fire = (win >= 0);
`ifdef SDFA_OUT_THRESH_EN
        if (fire && v[win] < m_othr) fire = 1'b0;
`endif
        oh = '0;
        if (fire) oh[win] = 1'b1;
    endtask

    task automatic do_reset();
        int now;
        now = cyc;
        rstn = 1'b1; pixel_valid = 1'b0; train = 1'b0;
        set_valid = 1'b0; master_inf_valid = 1'b0; block_inf_valid = 1'b0;
        for (int k = now + 1; k <= now + 12; k++) begin
            exp_v.delete(k);
            exp_s.delete(k);
        end
        step();
        chk("reset_set_up_req", set_up_req, 1);
        chk("reset_image_req", image_req, 0);
        step();
        rstn = 1'b0;
    endtask

    task automatic load_cfg(input int thr, input int en, input int initv, input int othr);
        logic [11:0]  sv;
        logic [254:0] mv;
        logic [170:0] bv;
        for (int i = 0; i < 12; i++)  sv[i] = 1'($urandom);
        for (int i = 0; i < 255; i++) mv[i] = 1'($urandom);
        for (int i = 0; i < 171; i++) bv[i] = 1'($urandom);
        sv[7:0]   = thr[7:0];
        mv[9:0]   = en[9:0];
        mv[33:10] = othr[23:0];
        bv[15:0]  = initv[15:0];
        m_thr  = thr & 255;
        m_en   = en[9:0];
        m_init = int'($signed(initv[15:0]));
        m_othr = int'($signed(othr[23:0]));
        for (int t = 0; t < 255; t++) begin
            set_valid        = (t < 12);
            set_number       = (t < 12) ? sv[11-t] : 1'($urandom);
            master_inf_valid = 1'b1;
            master_in        = mv[254-t];
            block_inf_valid  = (t < 171);
            block_in         = (t < 171) ? bv[170-t] : 1'b0;
            step();
        end
        chk("set_up_req_during_cfg", set_up_req, 1);
        set_valid = 1'b0; master_inf_valid = 1'b0; block_inf_valid = 1'b0;
        step();
        chk("set_up_req_after_cfg", set_up_req, 0);
        chk("image_req_after_cfg", image_req, 1);
    endtask

    task automatic write_w(input int pix, input int cls, input int val);
        data_in        = '0;
        data_in[13:0]  = val[13:0];
        data_in[17:14] = cls[3:0];
        data_in[27:18] = pix[9:0];
        pixel_valid = 1'b1; train = 1'b1;
        step();
        pixel_valid = 1'b0; train = 1'b0;
        if (pix < 784 && cls < 10) mw[pix][cls] = int'($signed(val[13:0]));
    endtask

    task automatic clear_img();
        for (int p = 0; p < 784; p++) img[p] = 8'h00;
    endtask

    task automatic send_image(input int pause_at, input int pause_len, input int rst_idx,
                              input bit lit_en, input logic [9:0] lit);
        logic [9:0]  oh;
        logic [63:0] w;
        int          e;
        model_result(oh);
        if (lit_en) chk("model_pin", oh, lit);
        obs_n = 0; obs_bits = '0;
        e = 0;
        for (int k = 0; k < 98; k++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = img[8*k+i];
            data_in = w; pixel_valid = 1'b1; train = 1'b0;
            e = cyc + 1;
            step();
            if (k == 0) chk("image_req_drop", image_req, 0);
            if (k == pause_at) begin
                for (int j = 0; j < pause_len; j++) begin
                    pixel_valid = 1'b0;
                    data_in = {$urandom, $urandom};
                    step();
                end
            end
        end
        for (int j = 0; j < 10; j++) begin
            exp_v[e+1+j] = 1'b1;
            exp_s[e+1+j] = oh[j];
        end
        if (rst_idx >= 0) begin
            pixel_valid = 1'b0;
            repeat (rst_idx + 1) step();
            do_reset();
        end else begin
            for (int j = 0; j < 12; j++) begin
                if (j < 10) begin
                    pixel_valid = 1'b1;
                    train       = 1'($urandom);
                    data_in     = {36'd0, 10'd5, 4'd3, 14'($urandom)};
                end else begin
                    pixel_valid = 1'b0;
                    train       = 1'b0;
                end
                step();
            end
            chk("image_req_after_out", image_req, 1);
            chk("result_length", obs_n, 10);
            if (lit_en) chk("result_onehot", obs_bits, lit);
        end
    endtask

    initial begin
        rstn = 1'b1; data_in = '0; pixel_valid = 1'b0; train = 1'b0;
        set_number = 1'b0; set_valid = 1'b0; master_inf_valid = 1'b0;
        block_inf_valid = 1'b0; master_in = 1'b0; block_in = 1'b0;
        obs_n = 0; obs_bits = '0;
        step(); step();
        chk("rst_set_up_req", set_up_req, 1);
        chk("rst_image_req", image_req, 0);
        rstn = 1'b0;

        load_cfg(8'h80, 10'h3FF, -5, -1000);
        for (int p = 0; p < 784; p++)
            for (int c = 0; c < 10; c++) write_w(p, c, 0);
        write_w(5, 3, 100);
        write_w(5, 12, 77);
        write_w(800, 3, 77);

        clear_img(); img[5] = 8'hFF;
        send_image(-1, 0, -1, 1'b1, 10'b0000001000);
        clear_img(); img[5] = 8'h80;
        send_image(-1, 0, -1, 1'b1, 10'b0000001000);

        // Chain valids outside configuration must not disturb the settings.
        for (int t = 0; t < 40; t++) begin
            set_valid = 1'b1; master_inf_valid = 1'b1; block_inf_valid = 1'b1;
            set_number = 1'b0; master_in = 1'b0; block_in = 1'b1;
            step();
        end
        set_valid = 1'b0; master_inf_valid = 1'b0; block_inf_valid = 1'b0;
        step();

        clear_img(); img[5] = 8'h7F;
        send_image(-1, 0, -1, 1'b1, 10'b0000000001);

        write_w(0, 2, 50);
        write_w(0, 7, 50);
        clear_img(); img[0] = 8'hFF;
        send_image(-1, 0, -1, 1'b1, 10'b0000000100);

        clear_img(); img[5] = 8'hFF;
        send_image(40, 5, -1, 1'b1, 10'b0000001000);

        do_reset();
        load_cfg(8'h80, 10'h3FB, -5, -1000);
        clear_img(); img[0] = 8'hFF;
        send_image(-1, 0, -1, 1'b1, 10'b0010000000);

        do_reset();
        load_cfg(8'h80, 10'h000, -5, -1000);
        send_image(-1, 0, -1, 1'b1, 10'b0000000000);

        do_reset();
        load_cfg(8'h80, 10'h3FF, -5, -1000);
        clear_img(); img[5] = 8'hFF;
        send_image(-1, 0, 4, 1'b0, 10'b0);
        load_cfg(8'h80, 10'h3FF, -5, -1000);
        send_image(-1, 0, -1, 1'b1, 10'b0000001000);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            load_cfg(int'($urandom_range(0, 255)), int'($urandom_range(1, 1023)),
                     int'($urandom_range(0, 65535)), int'($urandom_range(0, 60000)) - 30000);
            for (int n = 0; n < 150; n++)
                write_w(int'($urandom_range(0, 783)), int'($urandom_range(0, 9)),
                        int'($urandom_range(0, 16383)) - 8192);
            for (int n = 0; n < 2; n++) begin
                for (int p = 0; p < 784; p++) img[p] = 8'($urandom);
                send_image(int'($urandom_range(0, 96)), int'($urandom_range(0, 4)), -1, 1'b0, 10'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
